// File: rtl/mmcm_lock_supervisor.sv
// mmcm_lock_supervisor: sequences MMCM reset, supervises lock and releases a clean system reset
//   clk          : free-running buffered input clock (same as MMCM CLKIN1)
//   reset        : synchronous active-high supervisor reset
//   locked_in    : MMCM LOCKED, asynchronous to clk
//   clear_status : pulse clearing retry_count and lock_lost
//   mmcm_reset   : drives MMCM RST
//   rst_out      : active-high system reset to downstream logic
//   ready        : high only while lock is supervised as good
//   lock_lost    : sticky, lock dropped while running
//   retry_count  : saturating count of MMCM reset re-attempts
module mmcm_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    localparam int MAXC = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES)
        ? ((RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES)
        : ((LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES),
    localparam int CW = $clog2(MAXC) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked_in,
    input  logic       clear_status,
    output logic       mmcm_reset,
    output logic       rst_out,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_count
);
    typedef enum logic [1:0] {RESET_MMCM, WAIT_LOCK, STABILIZE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_sync, retry_inc, set_lost;

    assign locked_sync = sync_q[SYNC_STAGES-1];
    assign mmcm_reset  = state_q == RESET_MMCM;
    assign rst_out     = state_q != RUN;
    assign ready       = state_q == RUN;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_inc = 1'b0;
        set_lost  = 1'b0;
        case (state_q)
            RESET_MMCM: begin
                cnt_d   = (cnt_q == CW'(RST_PULSE_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(RST_PULSE_CYCLES - 1)) ? WAIT_LOCK : RESET_MMCM;
            end
            WAIT_LOCK: begin
                if (locked_sync) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_d   = RESET_MMCM;
                    cnt_d     = '0;
                    retry_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABILIZE: begin
                if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (!locked_sync) begin
                    state_d   = RESET_MMCM;
                    cnt_d     = '0;
                    retry_inc = 1'b1;
                    set_lost  = 1'b1;
                end
            end
        endcase
    end

    // A status event in the same cycle as clear_status wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_MMCM;
            cnt_q       <= '0;
            sync_q      <= '0;
            retry_count <= '0;
            lock_lost   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], locked_in};
            retry_count <= retry_inc ? (clear_status ? 8'd1 : (retry_count == 8'hFF ? retry_count : retry_count + 8'd1))
                                     : (clear_status ? 8'd0 : retry_count);
            lock_lost   <= set_lost ? 1'b1 : (clear_status ? 1'b0 : lock_lost);
        end
    end
endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// tb_mmcm_lock_supervisor: directed and randomized checks against a cycle-level behavioural model
module tb_mmcm_lock_supervisor;
    localparam int SYNC = 2;
    localparam int RSTP = 4;
    localparam int TOUT = 20;
    localparam int STAB = 8;
    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked_in = 1'b0;
    logic       clear_status = 1'b0;
    logic       mmcm_reset, rst_out, ready, lock_lost;
    logic [7:0] retry_count;

    int checks = 0;
    int errors = 0;

    int m_phase = P_RST;
    int m_el = 0;
    int m_retry = 0;
    bit m_lost = 0;
    bit hist[$];

    mmcm_lock_supervisor #(
        .SYNC_STAGES(SYNC), .RST_PULSE_CYCLES(RSTP),
        .LOCK_TIMEOUT_CYCLES(TOUT), .LOCK_STABLE_CYCLES(STAB)
    ) dut (
        .clk(clk), .reset(reset), .locked_in(locked_in), .clear_status(clear_status),
        .mmcm_reset(mmcm_reset), .rst_out(rst_out), .ready(ready),
        .lock_lost(lock_lost), .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // hist holds the last SYNC samples of locked_in, newest first; the oldest
    // one is what the supervisor acts on at the next edge.
    task automatic model_edge();
        bit ls, ev, lost_ev;
        ev = 0;
        lost_ev = 0;
        if (reset) begin
            m_phase = P_RST; m_el = 0; m_retry = 0; m_lost = 0;
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
            return;
        end
        ls = hist[$];
        hist.push_front(locked_in);
        void'(hist.pop_back());
        if (m_phase == P_RST) begin
            if (m_el + 1 == RSTP) begin m_phase = P_WAIT; m_el = 0; end
            else m_el++;
        end else if (m_phase == P_WAIT) begin
            if (ls) begin m_phase = P_STAB; m_el = 0; end
            else if (m_el + 1 == TOUT) begin m_phase = P_RST; m_el = 0; ev = 1; end
            else m_el++;
        end else if (m_phase == P_STAB) begin
            if (!ls) begin m_phase = P_WAIT; m_el = 0; end
            else if (m_el + 1 == STAB) m_phase = P_RUN;
            else m_el++;
        end else if (!ls) begin
            m_phase = P_RST; m_el = 0; ev = 1; lost_ev = 1;
        end
        if (ev) m_retry = clear_status ? 1 : (m_retry < 255 ? m_retry + 1 : 255);
        else if (clear_status) m_retry = 0;
        if (lost_ev) m_lost = 1;
        else if (clear_status) m_lost = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("mmcm_reset", mmcm_reset, m_phase == P_RST);
        chk("rst_out", rst_out, m_phase != P_RUN);
        chk("ready", ready, m_phase == P_RUN);
        chk("lock_lost", lock_lost, m_lost);
        chk("retry_count", retry_count, m_retry);
    endtask

    task automatic check_reset_values();
        chk("rv_mmcm_reset", mmcm_reset, 1);
        chk("rv_rst_out", rst_out, 1);
        chk("rv_ready", ready, 0);
        chk("rv_lock_lost", lock_lost, 0);
        chk("rv_retry", retry_count, 0);
    endtask

    task automatic release_sequence();
        for (int i = 1; i <= RSTP + 1 + STAB; i++) begin
            tick();
            chk("seq_mmcm_reset", mmcm_reset, i < RSTP);
            chk("seq_rst_out", rst_out, i < RSTP + 1 + STAB);
            chk("seq_ready", ready, i >= RSTP + 1 + STAB);
        end
        chk("seq_retry", retry_count, 0);
        chk("seq_lost", lock_lost, 0);
    endtask

    initial begin
        int guard;
        // 1: lock present from reset release
        reset = 1; locked_in = 1;
        tick();
        check_reset_values();
        reset = 0;
        release_sequence();

        // 3: one-cycle lock drop while running
        locked_in = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            locked_in = 1;
            chk("drop_rst_out", rst_out, i >= SYNC + 1);
            chk("drop_mmcm_reset", mmcm_reset, i >= SYNC + 1 && i <= SYNC + RSTP);
        end
        chk("drop_lost", lock_lost, 1);
        chk("drop_retry", retry_count, 1);
        repeat (16) tick();
        chk("drop_relock", ready, 1);

        // 2: lock absent for 60 cycles from reset release
        reset = 1; locked_in = 0;
        tick();
        reset = 0;
        repeat (60) tick();
        chk("timeout_retry", retry_count, 2);
        chk("timeout_mmcm_reset", mmcm_reset, 0);
        locked_in = 1;
        for (int k = 1; k <= SYNC + 1 + STAB; k++) begin
            tick();
            chk("late_lock_rst_out", rst_out, k < SYNC + 1 + STAB);
        end
        chk("late_lock_retry", retry_count, 2);

        // 4: glitch during the stable window with counter at 5
        reset = 1; locked_in = 1;
        tick();
        reset = 0;
        repeat (8) tick();
        locked_in = 0;
        tick();
        locked_in = 1;
        for (int e = 10; e <= 20; e++) begin
            tick();
            chk("glitch_rst_out", rst_out, e < 20);
        end
        chk("glitch_retry", retry_count, 0);

        // 5: saturation and clear precedence
        reset = 1; locked_in = 0;
        tick();
        reset = 0;
        repeat ((RSTP + TOUT) * 300) tick();
        chk("sat_retry", retry_count, 255);
        guard = 0;
        while (!(m_phase == P_WAIT && m_el == TOUT - 1) && guard < 40) begin
            tick();
            guard++;
        end
        chk("sat_find_timeout", guard < 40, 1);
        clear_status = 1;
        tick();
        clear_status = 0;
        chk("clear_vs_event_retry", retry_count, 1);
        tick();
        clear_status = 1;
        tick();
        clear_status = 0;
        chk("clear_quiet_retry", retry_count, 0);
        chk("clear_quiet_lost", lock_lost, 0);
        locked_in = 1;
        repeat (30) tick();
        chk("relock_ready", ready, 1);
        locked_in = 0;
        repeat (SYNC + 1) tick();
        chk("loss_lost", lock_lost, 1);
        chk("loss_retry", retry_count, 1);
        locked_in = 1;
        clear_status = 1;
        tick();
        clear_status = 0;
        chk("clear_lost", lock_lost, 0);
        chk("clear_lost_retry", retry_count, 0);
        repeat (20) tick();
        chk("run_again", ready, 1);

        // 6: reset pulse while running
        reset = 1;
        tick();
        check_reset_values();
        reset = 0;
        release_sequence();

        // randomized lock behaviour, clears and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) locked_in = ~locked_in;
            clear_status = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 0;
        clear_status = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
